register_unit_scheduler: RTL
============================

// Module: register_unit_scheduler
// PURPOSE
//  Front-end controller for the 32x32 register unit (write port RuDataWrite/rd/Ruwy, read ports rs1/rs2 -> Ru1/Ru2).
//  After reset it clears x1..x31, then shares the register unit between the single-cycle core and a debug/loader port.
//  The core has priority. A starvation counter bounds debug latency. Writes to x0 are always suppressed.
// PARAMETERS
//  XLEN       32  data width
//  NREGS      32  register count; REG_AW = $clog2(NREGS) = 5
//  MAX_WAIT   4   cycles a pending debug request may be denied before it is force-granted
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  core_valid   in   1      core uses the register unit this cycle
//  core_we      in   1      core write enable
//  core_rd      in   REG_AW core write address
//  core_wdata   in   XLEN   core write data
//  core_rs1     in   REG_AW core read address 1
//  core_rs2     in   REG_AW core read address 2
//  stall        out  1      core must hold its inputs; its write is not performed this cycle
//  ready        out  1      clear sweep done
//  dbg_req      in   1      debug request; held until dbg_ack
//  dbg_we       in   1      1 = write, 0 = read
//  dbg_addr     in   REG_AW debug register address
//  dbg_wdata    in   XLEN   debug write data
//  dbg_ack      out  1      one-cycle pulse, cycle after grant
//  dbg_rdata    out  XLEN   read data, valid while dbg_ack = 1
//  RuDataWrite  out  XLEN   to register unit
//  rd           out  REG_AW to register unit
//  rs1          out  REG_AW to register unit
//  rs2          out  REG_AW to register unit
//  Ruwy         out  1      register-unit write enable
//  Ru1          in   XLEN   from register unit, combinational read of rs1
// BEHAVIOUR
//  States: INIT, RUN, ACK. Reset -> INIT, idx = 0, wait_cnt = 0, ready = 0, dbg_ack = 0, dbg_rdata = 0.
//  Ruwy = wen_int && (rd != 0), always. Hence Ruwy = 0 while rst = 1 (rd = 0).
//  INIT: rd = idx, RuDataWrite = 0, wen_int = 1, stall = 1, no debug grant, wait_cnt held at 0.
//   idx increments 0..NREGS-1. On idx = NREGS-1 -> RUN, ready <= 1 (first RUN cycle = 32nd edge after reset release).
//  grant = (state == RUN) && dbg_req && (!core_valid || wait_cnt == MAX_WAIT).
//  RUN, no grant: rd/RuDataWrite/rs1/rs2 = core_*; wen_int = core_valid && core_we; stall = 0. Combinational; zero added latency.
//  RUN, grant:
//   rd = rs1 = dbg_addr; RuDataWrite = dbg_wdata; wen_int = dbg_we; rs2 = core_rs2.
//   stall = core_valid. dbg_rdata <= Ru1 (read) or dbg_wdata (write).
//   -> ACK, wait_cnt <= 0.
//  RUN, dbg_req && !grant: wait_cnt <= wait_cnt + 1, saturating at MAX_WAIT. No dbg_req: wait_cnt <= 0.
//  ACK: dbg_ack = 1; core path as in RUN; no grant even if dbg_req still high (prevents double-serve); -> RUN.
//  Debug write to x0: acked, no write. Debug read of x0 returns Ru1 (0).
//  Simultaneous core write and forced grant: the debug access wins; the core write is replayed by the core after stall.
//  Reset mid-INIT or mid-ACK: asynchronous return to INIT; sweep restarts at idx 0; pending ack is lost.
//  Width rule: wait_cnt is $clog2(MAX_WAIT+1) bits. idx is REG_AW bits, with no wrap past NREGS-1.
// STRUCTURE
//  register_unit_pkg: XLEN, NREGS, REG_AW constants; typedef enum logic [1:0] {INIT, RUN, ACK} ru_sched_state_t.
//  Single module; sweep counter and starvation counter inline. Output muxing is one always_comb block; state is one always_ff block.
// TESTING
//  1 Release rst: cycles 1..31 Ruwy = 1, rd = 1..31, RuDataWrite = 0, stall = 1; cycle 0 Ruwy = 0; ready = 1 from cycle 32.
//  2 RUN, core_valid = 1, core_we = 1, core_rd = 3, wdata = 0x3 -> same cycle Ruwy = 1, rd = 3; core_rd = 0 -> Ruwy = 0.
//  3 core_valid = 0, dbg write addr 5, 0xA5 -> grant, stall = 0, Ruwy = 1, rd = 5; next cycle dbg_ack = 1. Read addr 5 -> dbg_rdata = 0xA5.
//  4 core_valid = 1 held, dbg_req -> denied 4 cycles; 5th cycle grant, stall = 1 for exactly that cycle; ack the next cycle.
//  5 dbg_req held high through ACK -> no grant in ACK cycle; regrant possible the cycle after.
//  6 assert rst at idx = 10, and again during ACK -> dbg_ack = 0, ready = 0, Ruwy = 0 immediately; full 32-cycle sweep repeats.

Source files
------------

// File: rtl/register_unit_pkg.sv
// Shared constants, state encoding and helpers for the register-unit front-end scheduler.
package register_unit_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int REG_AW   = $clog2(NREGS);
    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        ACK  = 2'd2
    } ru_sched_state_t;

    // Starvation counter step that parks at MAX_WAIT instead of wrapping.
    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(MAX_WAIT)) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/register_unit_scheduler.sv
// Arbitrates the 32x32 register unit between the core and a debug/loader port,
// after clearing x1..x31 out of reset.
module register_unit_scheduler
    import register_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid,
    input  logic              core_we,
    input  logic [REG_AW-1:0] core_rd,
    input  logic [XLEN-1:0]   core_wdata,
    input  logic [REG_AW-1:0] core_rs1,
    input  logic [REG_AW-1:0] core_rs2,
    output logic              stall,
    output logic              ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_ack,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic [XLEN-1:0]   RuDataWrite,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic              Ruwy,
    input  logic [XLEN-1:0]   Ru1
);

    ru_sched_state_t   r_state;
    logic [REG_AW-1:0] r_idx;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_ready;
    logic              r_dbg_ack;
    logic [XLEN-1:0]   r_dbg_rdata;

    logic              w_grant;
    logic              w_wen;
    logic              w_stall;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [XLEN-1:0]   w_wdata;

    // Register-unit port muxing: sweep, core pass-through, or debug override.
    always_comb begin
        w_grant = (r_state == RUN) && dbg_req &&
                  (!core_valid || (r_wait_cnt == WAIT_W'(MAX_WAIT)));
        w_rd    = core_rd;
        w_rs1   = core_rs1;
        w_rs2   = core_rs2;
        w_wdata = core_wdata;
        w_wen   = core_valid && core_we;
        w_stall = 1'b0;
        case (r_state)
            INIT: begin
                w_rd    = r_idx;
                w_wdata = {XLEN{1'b0}};
                w_wen   = 1'b1;
                w_stall = 1'b1;
            end
            RUN, ACK: begin
                if (w_grant) begin
                    w_rd    = dbg_addr;
                    w_rs1   = dbg_addr;
                    w_wdata = dbg_wdata;
                    w_wen   = dbg_we;
                    w_stall = core_valid;
                end else begin
                    w_wen   = core_valid && core_we;
                    w_stall = 1'b0;
                end
            end
            default: begin
                w_wen   = 1'b0;
                w_stall = 1'b1;
            end
        endcase
    end

    assign rd          = w_rd;
    assign rs1         = w_rs1;
    assign rs2         = w_rs2;
    assign RuDataWrite = w_wdata;
    assign stall       = w_stall;
    assign Ruwy        = w_wen && (w_rd != {REG_AW{1'b0}});
    assign ready       = r_ready;
    assign dbg_ack     = r_dbg_ack;
    assign dbg_rdata   = r_dbg_rdata;

    // Scheduler state, clear-sweep index, starvation counter and debug response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_idx       <= {REG_AW{1'b0}};
            r_wait_cnt  <= {WAIT_W{1'b0}};
            r_ready     <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                INIT: begin
                    r_wait_cnt <= {WAIT_W{1'b0}};
                    r_dbg_ack  <= 1'b0;
                    if (r_idx == REG_AW'(NREGS - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + REG_AW'(1);
                    end
                end
                RUN: begin
                    if (w_grant) begin
                        r_dbg_rdata <= dbg_we ? dbg_wdata : Ru1;
                        r_dbg_ack   <= 1'b1;
                        r_wait_cnt  <= {WAIT_W{1'b0}};
                        r_state     <= ACK;
                    end else if (dbg_req) begin
                        r_dbg_ack  <= 1'b0;
                        r_wait_cnt <= wait_sat_inc(r_wait_cnt);
                    end else begin
                        r_dbg_ack  <= 1'b0;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end
                end
                ACK: begin
                    // The ack cycle never grants, so a still-high request cannot be served twice.
                    r_dbg_ack <= 1'b0;
                    r_state   <= RUN;
                end
                default: begin
                    r_state   <= INIT;
                    r_idx     <= {REG_AW{1'b0}};
                    r_ready   <= 1'b0;
                    r_dbg_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule
